// File: rtl/render_seq_ctrl.sv
// render_seq_ctrl: sequences queued render commands toward the line-draw and
// clear datapaths. Commands enter a FIFO over a valid/ready handshake and are
// executed one at a time by a small FSM.
//
// Ports:
//   clk, n_rst      clock, asynchronous active-low reset
//   cmd_valid/op    command offer and op code; cmd_ready = FIFO not full
//   abort           synchronous abort: flush FIFO, back to IDLE, clear tmo_err
//   done            line drawer finished (sampled on the last settle cycle)
//   clear_done      clear engine finished
//   draw_enable, set_new, enable, line_draw_out, clear_enable
//                   datapath strobes decoded from the FSM state
//   render_done     registered one-cycle pulse per completed command
//   busy            FSM active or commands pending
//   tmo_err         sticky clear-watchdog timeout flag
//   q_count         FIFO occupancy
module render_seq_ctrl #(
    parameter int OP_W     = 3,
    parameter int OP_CLEAR = 0,
    parameter int QDEPTH   = 4,
    parameter int WAIT_CYC = 2,
    parameter int TMO_W    = 16
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      cmd_valid,
    input  logic [OP_W-1:0]           cmd_op,
    output logic                      cmd_ready,
    input  logic                      abort,
    input  logic                      done,
    input  logic                      clear_done,
    output logic                      draw_enable,
    output logic                      set_new,
    output logic                      enable,
    output logic                      line_draw_out,
    output logic                      clear_enable,
    output logic                      render_done,
    output logic                      busy,
    output logic                      tmo_err,
    output logic [$clog2(QDEPTH):0]   q_count
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam int WW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

    localparam logic [CW-1:0]    FULL_C    = CW'(QDEPTH);
    localparam logic [OP_W-1:0]  CLR_OP    = OP_W'(OP_CLEAR);
    localparam logic [WW-1:0]    WAIT_LOAD = WW'(WAIT_CYC - 1);
    // Value seen on the last permitted clear cycle: one more increment
    // would make the watchdog all-ones.
    localparam logic [TMO_W-1:0] TMO_LAST  = {{(TMO_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_NEXT_INIT = 3'd1,
        S_NEXT      = 3'd2,
        S_SEND      = 3'd3,
        S_SWAIT     = 3'd4,
        S_CLRSND    = 3'd5,
        S_FIN       = 3'd6
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [OP_W-1:0]   mem_r [QDEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic [WW-1:0]     wait_r;
    logic [TMO_W-1:0]  wd_r;
    logic              render_done_r;
    logic              tmo_err_r;

    logic              empty_s;
    logic              push_s;
    logic              pop_s;
    logic              wait_zero_s;
    logic              timeout_s;

    assign empty_s     = (count_r == {CW{1'b0}});
    assign cmd_ready   = (count_r != FULL_C);
    // A push during abort is discarded along with the rest of the queue.
    assign push_s      = cmd_valid & cmd_ready & ~abort;
    assign pop_s       = (state_r == S_IDLE) & ~empty_s & ~abort;
    assign wait_zero_s = (wait_r == {WW{1'b0}});
    assign timeout_s   = (state_r == S_CLRSND) & (wd_r == TMO_LAST);

    assign busy        = (state_r != S_IDLE) | ~empty_s;
    assign q_count     = count_r;
    assign render_done = render_done_r;
    assign tmo_err     = tmo_err_r;

    // FIFO storage write port (contents are don't-care while empty).
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= cmd_op;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (abort) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; abort overrides every transition.
    always_comb begin
        state_s = state_r;
        if (abort) begin
            state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (empty_s) begin
                        state_s = S_IDLE;
                    end else if (mem_r[rd_ptr_r] == CLR_OP) begin
                        state_s = S_CLRSND;
                    end else begin
                        state_s = S_NEXT_INIT;
                    end
                end
                S_NEXT_INIT: state_s = S_SEND;
                S_NEXT:      state_s = S_SEND;
                S_SEND:      state_s = S_SWAIT;
                S_SWAIT: begin
                    if (!wait_zero_s) begin
                        state_s = S_SWAIT;
                    end else if (done) begin
                        state_s = S_FIN;
                    end else begin
                        state_s = S_NEXT;
                    end
                end
                S_CLRSND: begin
                    if (clear_done || timeout_s) begin
                        state_s = S_FIN;
                    end else begin
                        state_s = S_CLRSND;
                    end
                end
                S_FIN:   state_s = S_IDLE;
                default: state_s = S_IDLE;
            endcase
        end
    end

    // FSM output decode (pure function of the registered state).
    always_comb begin
        draw_enable   = 1'b0;
        set_new       = 1'b0;
        enable        = 1'b0;
        line_draw_out = 1'b0;
        clear_enable  = 1'b0;
        case (state_r)
            S_NEXT_INIT: begin
                draw_enable   = 1'b1;
                set_new       = 1'b1;
                line_draw_out = 1'b1;
            end
            S_NEXT: begin
                draw_enable   = 1'b1;
                line_draw_out = 1'b1;
            end
            S_SEND: begin
                enable        = 1'b1;
                line_draw_out = 1'b1;
            end
            S_SWAIT: begin
                line_draw_out = 1'b1;
            end
            S_CLRSND: begin
                clear_enable  = 1'b1;
                enable        = 1'b1;
            end
            default: begin
                draw_enable   = 1'b0;
            end
        endcase
    end

    // Settle counter: loaded on SEND, counts down through SWAIT.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wait_r <= {WW{1'b0}};
        end else if (abort) begin
            wait_r <= {WW{1'b0}};
        end else if (state_r == S_SEND) begin
            wait_r <= WAIT_LOAD;
        end else if ((state_r == S_SWAIT) && !wait_zero_s) begin
            wait_r <= wait_r - WW'(1);
        end else begin
            wait_r <= wait_r;
        end
    end

    // Clear watchdog: counts CLRSND cycles, zero everywhere else.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wd_r <= {TMO_W{1'b0}};
        end else if (abort) begin
            wd_r <= {TMO_W{1'b0}};
        end else if (state_r == S_CLRSND) begin
            wd_r <= wd_r + TMO_W'(1);
        end else begin
            wd_r <= {TMO_W{1'b0}};
        end
    end

    // Completion pulse and sticky timeout flag; clear_done beats a timeout.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            render_done_r <= 1'b0;
            tmo_err_r     <= 1'b0;
        end else if (abort) begin
            render_done_r <= 1'b0;
            tmo_err_r     <= 1'b0;
        end else begin
            render_done_r <= (state_r == S_FIN);
            if (timeout_s && !clear_done) begin
                tmo_err_r <= 1'b1;
            end
        end
    end

endmodule
